// File: rtl/carrier_pkg.sv
`default_nettype none
// ============================================================================
// Module      : carrier_pkg
// Description : Shared constants and types for the level-shifted carrier
//               generator and its prescaler.
// Revision    : 1.0 - initial release
// ============================================================================
package carrier_pkg;

    // Top of the unsigned triangle; the upper carrier peaks here
    localparam int CARRIER_MAX  = 32767;
    // Offset that stacks the lower carrier directly beneath the upper one
    localparam int LOWER_OFFSET = -32768;

    // Triangle slope direction
    typedef enum logic [0:0] {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Divides the system clock down to triangle step ticks. A tick
//               fires when the counter reaches div_sh, then the counter wraps
//               to zero, giving one tick every div_sh+1 enabled cycles. The
//               counter is held at zero while disabled and cleared by a phase
//               reset so the next step is a full interval away.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [DIV_WIDTH-1:0] div_sh,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] r_pcnt;
    logic                 w_wrap;

    assign w_wrap = (r_pcnt == div_sh);
    assign tick   = enable & w_wrap;

    // Prescale counter: 0..div_sh, cleared when idle or on phase reset
    always_ff @(posedge clk) begin
        if (rst || !enable || clear) begin
            r_pcnt <= '0;
        end else if (w_wrap) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/carrier_gen_ls.sv
`default_nettype none
// ============================================================================
// Module      : carrier_gen_ls
// Description : Level-shifted triangular carrier pair for a 5-level cascaded
//               H-bridge modulator. carrier1 spans 0..32767 and carrier2 is
//               the same triangle shifted down by 32768. Divider and step are
//               shadowed and only change at a valley, on a phase reset, or
//               while idle, so updates never distort a running period.
// Revision    : 1.0 - initial release
// ============================================================================
module carrier_gen_ls
    import carrier_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [DIV_WIDTH-1:0]         div,
    input  logic [DATA_WIDTH-1:0]        step,
    input  logic                         sync_in,
    output logic signed [DATA_WIDTH-1:0] carrier1,
    output logic signed [DATA_WIDTH-1:0] carrier2,
    output logic                         dir_up,
    output logic                         sync_valley,
    output logic                         sync_peak
);

    // Triangle is one bit narrower than the signed carrier
    localparam int                  c_TRI_W   = DATA_WIDTH - 1;
    localparam logic [c_TRI_W-1:0]  c_TRI_MAX = c_TRI_W'(CARRIER_MAX);

    // Registered state
    logic [c_TRI_W-1:0]    r_tri;
    dir_e                  r_dir;
    logic                  r_valley;
    logic                  r_peak;
    logic [DIV_WIDTH-1:0]  r_div_sh;
    logic [DATA_WIDTH-1:0] r_step_sh;

    // Next-state
    logic [c_TRI_W-1:0]    w_tri_nxt;
    dir_e                  w_dir_nxt;
    logic                  w_valley_nxt;
    logic                  w_peak_nxt;
    logic                  w_reload;

    // Datapath helpers
    logic                  w_tick;
    logic [DATA_WIDTH-1:0] w_step_load;
    logic [DATA_WIDTH:0]   w_sum;
    logic [c_TRI_W-1:0]    w_diff;
    logic                  w_at_valley;

    // A zero step would stall the triangle, so it is loaded as one
    assign w_step_load = (step == '0) ? DATA_WIDTH'(1) : step;

    // Wide sum so steps larger than the remaining headroom cannot wrap
    assign w_sum       = {2'b00, r_tri} + {1'b0, r_step_sh};
    assign w_at_valley = ({1'b0, r_tri} <= r_step_sh);
    // Only used when the step is smaller than tri, so truncation is safe
    assign w_diff      = r_tri - r_step_sh[c_TRI_W-1:0];

    tick_prescaler #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_tick_prescaler (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .clear  (sync_in),
        .div_sh (r_div_sh),
        .tick   (w_tick)
    );

    // Triangle next-state: idle, phase reset, then slope / turnaround
    always_comb begin
        w_tri_nxt    = r_tri;
        w_dir_nxt    = r_dir;
        w_valley_nxt = 1'b0;
        w_peak_nxt   = 1'b0;
        w_reload     = 1'b0;
        if (!enable) begin
            w_tri_nxt = '0;
            w_dir_nxt = DIR_UP;
            w_reload  = 1'b1;
        end else if (sync_in) begin
            w_tri_nxt    = '0;
            w_dir_nxt    = DIR_UP;
            w_valley_nxt = 1'b1;
            w_reload     = 1'b1;
        end else if (w_tick) begin
            if (r_dir == DIR_UP) begin
                if (w_sum >= {2'b00, c_TRI_MAX}) begin
                    w_tri_nxt  = c_TRI_MAX;
                    w_dir_nxt  = DIR_DOWN;
                    w_peak_nxt = 1'b1;
                end else begin
                    w_tri_nxt = w_sum[c_TRI_W-1:0];
                end
            end else begin
                if (w_at_valley) begin
                    w_tri_nxt    = '0;
                    w_dir_nxt    = DIR_UP;
                    w_valley_nxt = 1'b1;
                    w_reload     = 1'b1;
                end else begin
                    w_tri_nxt = w_diff;
                end
            end
        end
    end

    // State, strobe and shadow registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tri     <= '0;
            r_dir     <= DIR_UP;
            r_valley  <= 1'b0;
            r_peak    <= 1'b0;
            r_div_sh  <= '0;
            r_step_sh <= DATA_WIDTH'(1);
        end else begin
            r_tri    <= w_tri_nxt;
            r_dir    <= w_dir_nxt;
            r_valley <= w_valley_nxt;
            r_peak   <= w_peak_nxt;
            if (w_reload) begin
                r_div_sh  <= div;
                r_step_sh <= w_step_load;
            end
        end
    end

    assign carrier1    = {1'b0, r_tri};
    assign carrier2    = $signed({1'b0, r_tri}) + DATA_WIDTH'(LOWER_OFFSET);
    assign dir_up      = (r_dir == DIR_UP);
    assign sync_valley = r_valley;
    assign sync_peak   = r_peak;

endmodule
`default_nettype wire

// File: tb/tb_carrier_gen_ls.sv
`default_nettype none
// ============================================================================
// Module      : tb_carrier_gen_ls
// Description : Directed self-checking bench for carrier_gen_ls.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_carrier_gen_ls;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic [15:0]        div;
    logic [15:0]        step;
    logic               sync_in;
    logic signed [15:0] carrier1;
    logic signed [15:0] carrier2;
    logic               dir_up;
    logic               sync_valley;
    logic               sync_peak;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    carrier_gen_ls #(
        .DATA_WIDTH (16),
        .DIV_WIDTH  (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .div         (div),
        .step        (step),
        .sync_in     (sync_in),
        .carrier1    (carrier1),
        .carrier2    (carrier2),
        .dir_up      (dir_up),
        .sync_valley (sync_valley),
        .sync_peak   (sync_peak)
    );

    // Advance n edges and settle just after the last one
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One idle cycle loads the shadows, then the generator is enabled
    task automatic start(input int d, input int s);
        enable  = 1'b0;
        sync_in = 1'b0;
        div     = 16'(d);
        step    = 16'(s);
        cyc(1);
        enable  = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; sync_in = 1'b0; div = 16'd0; step = 16'd4096;
        cyc(1);
        checks++;
        if ({carrier1, carrier2, dir_up, sync_valley, sync_peak} !==
            {16'sd0, -16'sd32768, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state c1=%0d c2=%0d dir=%b val=%b pk=%b exp c1=0 c2=-32768 dir=1 val=0 pk=0",
                     carrier1, carrier2, dir_up, sync_valley, sync_peak);
        end
        // Reset shadows are div=0 / step=1, so three enabled edges give 3
        rst = 1'b0;
        cyc(3);
        checks++;
        if (carrier1 !== 16'sd3) begin
            failures++;
            $display("FAIL reset_shadow c1=%0d exp=3", carrier1);
        end
        // Reset wins over a coincident sync_in
        rst = 1'b1; sync_in = 1'b1;
        cyc(1);
        checks++;
        if ({carrier1, dir_up, sync_valley, sync_peak} !== {16'sd0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_midrun c1=%0d dir=%b val=%b pk=%b exp c1=0 dir=1 val=0 pk=0",
                     carrier1, dir_up, sync_valley, sync_peak);
        end
        rst = 1'b0; sync_in = 1'b0; enable = 1'b0;
        cyc(1);
    endtask

    task automatic test_fast();
        int tab [16] = '{0, 4096, 8192, 12288, 16384, 20480, 24576, 28672,
                         32767, 28671, 24575, 20479, 16383, 12287, 8191, 4095};
        logic signed [15:0] e_c1, e_c2;
        logic e_dir, e_val, e_pk;
        start(0, 4096);
        for (int k = 1; k <= 32; k++) begin
            int idx;
            cyc(1);
            idx   = k % 16;
            e_c1  = 16'(tab[idx]);
            e_c2  = 16'(tab[idx] - 32768);
            e_dir = (idx < 8);
            e_pk  = (idx == 8);
            e_val = (idx == 0);
            checks++;
            if ({carrier1, carrier2, dir_up, sync_valley, sync_peak} !==
                {e_c1, e_c2, e_dir, e_val, e_pk}) begin
                failures++;
                $display("FAIL fast k=%0d c1=%0d/%0d c2=%0d/%0d dir=%b/%b val=%b/%b pk=%b/%b",
                         k, carrier1, e_c1, carrier2, e_c2, dir_up, e_dir,
                         sync_valley, e_val, sync_peak, e_pk);
            end
        end
    endtask

    task automatic test_prescaler();
        int tab [8] = '{0, 8192, 16384, 24576, 32767, 24575, 16383, 8191};
        logic signed [15:0] e_c1;
        logic e_dir, e_val, e_pk;
        start(3, 8192);
        for (int k = 1; k <= 40; k++) begin
            int idx;
            cyc(1);
            idx   = (k / 4) % 8;
            e_c1  = 16'(tab[idx]);
            e_dir = (idx < 4);
            e_pk  = (k % 4 == 0) && (idx == 4);
            e_val = (k % 4 == 0) && (idx == 0);
            checks++;
            if ({carrier1, dir_up, sync_valley, sync_peak} !== {e_c1, e_dir, e_val, e_pk}) begin
                failures++;
                $display("FAIL prescaler k=%0d c1=%0d/%0d dir=%b/%b val=%b/%b pk=%b/%b",
                         k, carrier1, e_c1, dir_up, e_dir, sync_valley, e_val, sync_peak, e_pk);
            end
        end
    endtask

    task automatic test_shadow();
        int tab16 [16] = '{0, 4096, 8192, 12288, 16384, 20480, 24576, 28672,
                           32767, 28671, 24575, 20479, 16383, 12287, 8191, 4095};
        int tab8 [8]   = '{0, 8192, 16384, 24576, 32767, 24575, 16383, 8191};
        logic signed [15:0] e_c1;
        logic e_dir, e_val, e_pk;
        start(0, 4096);
        for (int k = 1; k <= 32; k++) begin
            int idx;
            cyc(1);
            if (k == 3) step = 16'd8192;
            if (k <= 16) begin
                idx   = k % 16;
                e_c1  = 16'(tab16[idx]);
                e_dir = (idx < 8);
                e_pk  = (idx == 8);
                e_val = (idx == 0);
            end else begin
                idx   = (k - 16) % 8;
                e_c1  = 16'(tab8[idx]);
                e_dir = (idx < 4);
                e_pk  = (idx == 4);
                e_val = (idx == 0);
            end
            checks++;
            if ({carrier1, dir_up, sync_valley, sync_peak} !== {e_c1, e_dir, e_val, e_pk}) begin
                failures++;
                $display("FAIL shadow k=%0d c1=%0d/%0d dir=%b/%b val=%b/%b pk=%b/%b",
                         k, carrier1, e_c1, dir_up, e_dir, sync_valley, e_val, sync_peak, e_pk);
            end
        end
    endtask

    task automatic test_phase_reset();
        // step 1117: peak after 30 ticks, then 11 falling ticks reach 20480
        start(0, 1117);
        cyc(41);
        checks++;
        if ({carrier1, dir_up} !== {16'sd20480, 1'b0}) begin
            failures++;
            $display("FAIL phase_pre c1=%0d dir=%b exp c1=20480 dir=0", carrier1, dir_up);
        end
        step = 16'd4096; sync_in = 1'b1;
        cyc(1);
        sync_in = 1'b0;
        checks++;
        if ({carrier1, carrier2, dir_up, sync_valley, sync_peak} !==
            {16'sd0, -16'sd32768, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL phase_sync c1=%0d c2=%0d dir=%b val=%b pk=%b exp c1=0 c2=-32768 dir=1 val=1 pk=0",
                     carrier1, carrier2, dir_up, sync_valley, sync_peak);
        end
        cyc(1);
        checks++;
        if ({carrier1, dir_up, sync_valley} !== {16'sd4096, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL phase_reload c1=%0d dir=%b val=%b exp c1=4096 dir=1 val=0",
                     carrier1, dir_up, sync_valley);
        end
        // sync_in on the cycle a tick is due
        start(3, 8192);
        cyc(3);
        sync_in = 1'b1;
        cyc(1);
        sync_in = 1'b0;
        checks++;
        if ({carrier1, dir_up, sync_valley} !== {16'sd0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL sync_vs_tick c1=%0d dir=%b val=%b exp c1=0 dir=1 val=1",
                     carrier1, dir_up, sync_valley);
        end
        cyc(3);
        checks++;
        if ({carrier1, sync_valley} !== {16'sd0, 1'b0}) begin
            failures++;
            $display("FAIL sync_pcnt_hold c1=%0d val=%b exp c1=0 val=0", carrier1, sync_valley);
        end
        cyc(1);
        checks++;
        if (carrier1 !== 16'sd8192) begin
            failures++;
            $display("FAIL sync_pcnt_step c1=%0d exp=8192", carrier1);
        end
    endtask

    task automatic test_edges();
        logic signed [15:0] e_c1;
        logic e_dir, e_val, e_pk;
        start(0, 0);
        for (int k = 1; k <= 3; k++) begin
            cyc(1);
            checks++;
            if ({carrier1, dir_up} !== {16'(k), 1'b1}) begin
                failures++;
                $display("FAIL step_zero k=%0d c1=%0d dir=%b exp c1=%0d dir=1", k, carrier1, dir_up, k);
            end
        end
        start(0, 40000);
        for (int k = 1; k <= 4; k++) begin
            cyc(1);
            e_c1  = (k % 2 == 1) ? 16'sd32767 : 16'sd0;
            e_dir = (k % 2 == 0);
            e_pk  = (k % 2 == 1);
            e_val = (k % 2 == 0);
            checks++;
            if ({carrier1, dir_up, sync_valley, sync_peak} !== {e_c1, e_dir, e_val, e_pk}) begin
                failures++;
                $display("FAIL step_big k=%0d c1=%0d/%0d dir=%b/%b val=%b/%b pk=%b/%b",
                         k, carrier1, e_c1, dir_up, e_dir, sync_valley, e_val, sync_peak, e_pk);
            end
        end
        // Drop enable just before a peak, with sync_in asserted (ignored)
        start(0, 4096);
        cyc(7);
        enable = 1'b0; sync_in = 1'b1;
        cyc(1);
        sync_in = 1'b0;
        checks++;
        if ({carrier1, carrier2, dir_up, sync_valley, sync_peak} !==
            {16'sd0, -16'sd32768, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL disable c1=%0d c2=%0d dir=%b val=%b pk=%b exp c1=0 c2=-32768 dir=1 val=0 pk=0",
                     carrier1, carrier2, dir_up, sync_valley, sync_peak);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; sync_in = 1'b0; div = 16'd0; step = 16'd0;
        test_reset();
        test_fast();
        test_prescaler();
        test_shadow();
        test_phase_reset();
        test_edges();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
